// File: rtl/pacman_motion_ctrl.sv
// Pac-Man movement controller: latches direction requests, decides turns at
// cell centres from the legal-move mask and steps the pixel position once per tick.
module pacman_motion_ctrl #(
  parameter int unsigned TICK_DIV  = 416667,
  parameter int unsigned STEP      = 2,
  parameter int unsigned CELL      = 60,
  parameter int unsigned X0        = 150,
  parameter int unsigned Y0        = 34,
  parameter int unsigned START_COL = 3,
  parameter int unsigned START_ROW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_en,
  input  logic       respawn,
  input  logic [3:0] btn,
  input  logic [3:0] legal_moves,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic [3:0] current_direction,
  output logic       moving,
  output logic       at_center,
  output logic       step_pulse
);

  localparam int unsigned POS_W  = 10;
  localparam int unsigned DIR_W  = 4;
  localparam int unsigned TCNT_W = 20;
  localparam int unsigned OFF_W  = $clog2(CELL);

  localparam logic [POS_W-1:0] X_START = POS_W'(X0 + START_COL * CELL);
  localparam logic [POS_W-1:0] Y_START = POS_W'(Y0 + START_ROW * CELL);
  localparam logic [POS_W-1:0] X_LO    = POS_W'(X0 + STEP);
  localparam logic [POS_W-1:0] X_HI    = POS_W'(X0 + 7 * CELL - STEP);
  localparam logic [POS_W-1:0] Y_LO    = POS_W'(Y0 + STEP);
  localparam logic [POS_W-1:0] Y_HI    = POS_W'(Y0 + 7 * CELL - STEP);
  localparam logic [POS_W-1:0] STEP_P  = POS_W'(STEP);

  localparam logic [DIR_W-1:0] DIR_L = 4'b1000;
  localparam logic [DIR_W-1:0] DIR_R = 4'b0100;
  localparam logic [DIR_W-1:0] DIR_U = 4'b0010;
  localparam logic [DIR_W-1:0] DIR_D = 4'b0001;

  typedef enum logic {STOP, MOVE} state_t;

  state_t             state;
  logic [TCNT_W-1:0]  tcnt;
  logic [OFF_W-1:0]   xoff, yoff;
  logic [DIR_W-1:0]   pend;

  logic               tick;
  logic [DIR_W-1:0]   opp_dir;
  logic [DIR_W-1:0]   d;
  logic               take_pend, go_stop, blocked, stepped;
  logic [POS_W-1:0]   x_n, y_n;
  logic [OFF_W-1:0]   xoff_n, yoff_n;
  logic [DIR_W-1:0]   pend_n;

  // Offset advance with wrap at the cell pitch.
  function automatic logic [OFF_W-1:0] off_inc(input logic [OFF_W-1:0] o);
    if (({1'b0, o} + (OFF_W+1)'(STEP)) == (OFF_W+1)'(CELL)) return '0;
    return o + OFF_W'(STEP);
  endfunction

  function automatic logic [OFF_W-1:0] off_dec(input logic [OFF_W-1:0] o);
    if (o == '0) return OFF_W'(CELL - STEP);
    return o - OFF_W'(STEP);
  endfunction

  assign tick    = game_en && (tcnt == TCNT_W'(TICK_DIV - 1));
  assign opp_dir = {current_direction[2], current_direction[3],
                    current_direction[0], current_direction[1]};

  // Direction decision, bounded step and request latch for this cycle.
  always_comb begin
    d         = '0;
    take_pend = 1'b0;
    go_stop   = 1'b0;
    blocked   = 1'b0;
    x_n       = xpos;
    y_n       = ypos;
    xoff_n    = xoff;
    yoff_n    = yoff;
    pend_n    = pend;

    if (at_center) begin
      if ((pend != '0) && ((pend & legal_moves) != '0)) begin
        d         = pend;
        take_pend = 1'b1;
      end else if ((state == MOVE) && ((current_direction & legal_moves) != '0)) begin
        d = current_direction;
      end else begin
        go_stop = 1'b1;
      end
    end else if (state == MOVE) begin
      if ((pend != '0) && (pend == opp_dir)) begin
        d         = pend;
        take_pend = 1'b1;
      end else begin
        d = current_direction;
      end
    end

    case (d)
      DIR_L: if (xpos < X_LO) blocked = 1'b1;
             else begin x_n = xpos - STEP_P; xoff_n = off_dec(xoff); end
      DIR_R: if (xpos > X_HI) blocked = 1'b1;
             else begin x_n = xpos + STEP_P; xoff_n = off_inc(xoff); end
      DIR_U: if (ypos < Y_LO) blocked = 1'b1;
             else begin y_n = ypos - STEP_P; yoff_n = off_dec(yoff); end
      DIR_D: if (ypos > Y_HI) blocked = 1'b1;
             else begin y_n = ypos + STEP_P; yoff_n = off_inc(yoff); end
      default: ;
    endcase

    stepped = (d != '0) && !blocked;

    // A fresh press replaces whatever a tick just consumed.
    if (tick && take_pend) pend_n = '0;
    if (btn[3])      pend_n = DIR_L;
    else if (btn[2]) pend_n = DIR_R;
    else if (btn[1]) pend_n = DIR_U;
    else if (btn[0]) pend_n = DIR_D;
  end

  // State, position and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= STOP;
      tcnt              <= '0;
      xoff              <= '0;
      yoff              <= '0;
      pend              <= '0;
      xpos              <= X_START;
      ypos              <= Y_START;
      current_direction <= '0;
      moving            <= 1'b0;
      at_center         <= 1'b1;
      step_pulse        <= 1'b0;
    end else if (respawn) begin
      state             <= STOP;
      tcnt              <= '0;
      xoff              <= '0;
      yoff              <= '0;
      pend              <= '0;
      xpos              <= X_START;
      ypos              <= Y_START;
      current_direction <= '0;
      moving            <= 1'b0;
      at_center         <= 1'b1;
      step_pulse        <= 1'b0;
    end else if (game_en) begin
      tcnt       <= tick ? '0 : tcnt + TCNT_W'(1);
      pend       <= pend_n;
      step_pulse <= tick && stepped;
      if (tick) begin
        if (go_stop || blocked) begin
          state  <= STOP;
          moving <= 1'b0;
        end else if (stepped) begin
          state             <= MOVE;
          moving            <= 1'b1;
          xpos              <= x_n;
          ypos              <= y_n;
          xoff              <= xoff_n;
          yoff              <= yoff_n;
          current_direction <= d;
          at_center         <= (xoff_n == '0) && (yoff_n == '0);
        end
      end
    end else begin
      step_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Directed bench for pacman_motion_ctrl with a 4-cycle game tick.
module tb_pacman_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game_en;
  logic       respawn;
  logic [3:0] btn;
  logic [3:0] legal_moves;
  logic [9:0] xpos, ypos;
  logic [3:0] current_direction;
  logic       moving, at_center, step_pulse;

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  bit last_tick = 1'b0;
  bit seen_pulse;

  pacman_motion_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .game_en(game_en), .respawn(respawn),
    .btn(btn), .legal_moves(legal_moves), .xpos(xpos), .ypos(ypos),
    .current_direction(current_direction), .moving(moving),
    .at_center(at_center), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; the bench tracks its own tick phase from the inputs it drives.
  task automatic clk1();
    bit t;
    t = 1'b0;
    @(posedge clk);
    if (respawn) phase = 0;
    else if (game_en) begin
      t = (phase == 3);
      phase = t ? 0 : phase + 1;
    end
    last_tick = t;
    #1;
  endtask

  task automatic next_tick();
    for (int i = 0; i < 8; i++) begin
      clk1();
      if (last_tick) return;
    end
    errors++;
    $error("FAIL tick_wait observed=0 expected=1");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) next_tick();
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(xpos), 32'(x));
    chk({tag, "_y"}, 32'(ypos), 32'(y));
  endtask

  initial begin
    rst_n = 1'b0; game_en = 1'b0; respawn = 1'b0; btn = '0; legal_moves = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_pos("rst", 330, 274);
    chk("rst_dir", 32'(current_direction), 32'd0);
    chk("rst_moving", 32'(moving), 32'd0);
    chk("rst_center", 32'(at_center), 32'd1);
    chk("rst_pulse", 32'(step_pulse), 32'd0);
    rst_n = 1'b1; game_en = 1'b1; phase = 0;

    // Idle: no requests, no movement.
    seen_pulse = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clk1();
      seen_pulse = seen_pulse | step_pulse;
    end
    chk("idle_pulse", 32'(seen_pulse), 32'd0);
    chk_pos("idle", 330, 274);

    // Move down from the start cell.
    btn = 4'b0001; legal_moves = 4'b0001;
    next_tick();
    chk_pos("down1", 330, 276);
    chk("down1_dir", 32'(current_direction), 32'd1);
    chk("down1_pulse", 32'(step_pulse), 32'd1);
    chk("down1_moving", 32'(moving), 32'd1);
    chk("down1_center", 32'(at_center), 32'd0);
    btn = '0;
    clk1();
    chk("down1_pulse_end", 32'(step_pulse), 32'd0);
    ticks(29);
    chk_pos("down30", 330, 334);
    chk("down30_center", 32'(at_center), 32'd1);

    // Wall ahead at a centre: stop, keep direction.
    legal_moves = 4'b0000;
    next_tick();
    chk_pos("wall", 330, 334);
    chk("wall_moving", 32'(moving), 32'd0);
    chk("wall_dir", 32'(current_direction), 32'd1);
    chk("wall_pulse", 32'(step_pulse), 32'd0);

    // Resume, then request right mid-cell; turn only at the next centre.
    legal_moves = 4'b0001;
    next_tick();
    chk_pos("resume", 330, 336);
    btn = 4'b0100;
    clk1();
    btn = '0;
    ticks(29);
    chk_pos("pre_turn", 330, 394);
    chk("pre_turn_dir", 32'(current_direction), 32'd1);
    chk("pre_turn_center", 32'(at_center), 32'd1);
    legal_moves = 4'b0101;
    next_tick();
    chk_pos("turn", 332, 394);
    chk("turn_dir", 32'(current_direction), 32'd4);

    // Respawn returns to the start state.
    respawn = 1'b1;
    clk1();
    respawn = 1'b0;
    chk_pos("respawn", 330, 274);
    chk("respawn_dir", 32'(current_direction), 32'd0);
    chk("respawn_moving", 32'(moving), 32'd0);
    chk("respawn_center", 32'(at_center), 32'd1);

    // Reversal mid-cell ignores legal_moves.
    btn = 4'b0001; legal_moves = 4'b0001;
    next_tick();
    chk_pos("rev_start", 330, 276);
    btn = '0;
    ticks(4);
    chk_pos("rev_mid", 330, 284);
    btn = 4'b0010; legal_moves = 4'b0000;
    clk1();
    btn = '0;
    next_tick();
    chk_pos("rev", 330, 282);
    chk("rev_dir", 32'(current_direction), 32'd2);
    chk("rev_moving", 32'(moving), 32'd1);

    // Respawn on a tick cycle beats both the step and a simultaneous press.
    for (int i = 0; i < 8 && phase != 3; i++) clk1();
    respawn = 1'b1; btn = 4'b0001;
    clk1();
    respawn = 1'b0; btn = '0;
    chk_pos("resp_tick", 330, 274);
    chk("resp_tick_moving", 32'(moving), 32'd0);
    chk("resp_tick_pulse", 32'(step_pulse), 32'd0);
    legal_moves = 4'b1111;
    next_tick();
    chk_pos("resp_nopend", 330, 274);
    chk("resp_nopend_pulse", 32'(step_pulse), 32'd0);

    // Asynchronous reset mid-cell.
    btn = 4'b0001; legal_moves = 4'b0001;
    next_tick();
    btn = '0;
    chk_pos("pre_arst", 330, 276);
    #3 rst_n = 1'b0;
    #1;
    chk_pos("arst", 330, 274);
    chk("arst_dir", 32'(current_direction), 32'd0);
    chk("arst_pulse", 32'(step_pulse), 32'd0);
    chk("arst_center", 32'(at_center), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1; phase = 0;

    // game_en low freezes everything.
    btn = 4'b0001;
    next_tick();
    btn = '0;
    chk_pos("frz_start", 330, 276);
    game_en = 1'b0;
    seen_pulse = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk1();
      seen_pulse = seen_pulse | step_pulse;
    end
    chk_pos("frz", 330, 276);
    chk("frz_pulse", 32'(seen_pulse), 32'd0);
    game_en = 1'b1;
    next_tick();
    chk_pos("frz_resume", 330, 278);

    // Reverse upward and run into the top bound.
    btn = 4'b0010; legal_moves = 4'b0010;
    clk1();
    btn = '0;
    next_tick();
    chk_pos("up_rev", 330, 276);
    ticks(121);
    chk_pos("top", 330, 34);
    chk("top_center", 32'(at_center), 32'd1);
    next_tick();
    chk_pos("top_guard", 330, 34);
    chk("top_guard_moving", 32'(moving), 32'd0);
    chk("top_guard_pulse", 32'(step_pulse), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pacman_motion_ctrl.md
# pacman_motion_ctrl

Pac-Man movement controller. Latches the player's requested direction and advances Pac-Man's pixel position once per game tick. It decides turns at cell centres from the 4-bit legal-move mask, which the legal-move lookup derives combinationally from this block's own `xpos`/`ypos`/`current_direction` outputs. It sits directly upstream of the legal-move lookup and the sprite renderer.

## Interface
- `TICK_DIV`, 416667: clock cycles per game tick (60 Hz at 25 MHz).
- `STEP`, 2: pixels moved per tick; must divide `CELL`.
- `CELL`, 60: cell pitch in pixels.
- `X0`, 150: x pixel of column 0 centre.
- `Y0`, 34: y pixel of row 0 centre.
- `START_COL`, 3: respawn/reset column.
- `START_ROW`, 4: respawn/reset row.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `game_en` in 1: high runs the tick counter; low freezes the counter and all state.
- `respawn` in 1: synchronous pulse; returns the block to its reset state.
- `btn` in 4: debounced level requests, {left, right, up, down}.
- `legal_moves` in 4: {left, right, up, down} for the current cell; combinational from the outputs.
- `xpos` out 10: Pac-Man x pixel.
- `ypos` out 10: Pac-Man y pixel.
- `current_direction` out 4: one-hot {L,R,U,D}; 0000 means no direction.
- `moving` out 1: high in state MOVE.
- `at_center` out 1: high when both sub-cell offsets are 0.
- `step_pulse` out 1: one-cycle pulse after each position change.

## Operation
- Internal registers:
  - tick counter `tcnt`, 20 bits
  - `xoff`/`yoff`, 0..CELL-1
  - pending request `pend`, 4-bit one-hot or 0
  - FSM state {STOP, MOVE}
- Reset or `respawn`:
  - `xpos` = X0+START_COL*CELL (330)
  - `ypos` = Y0+START_ROW*CELL (274)
  - offsets 0, `pend`=0, `current_direction`=0000, state STOP, `tcnt`=0
  - `moving`=0, `at_center`=1, `step_pulse`=0
- Request latch, every cycle with `game_en`=1:
  - If any `btn` bit is high, `pend` ← the one-hot of the highest-priority high bit, priority L>R>U>D.
  - `pend` holds until it is consumed or replaced.
- Tick: `tcnt`==TICK_DIV-1 while `game_en`=1. `tcnt` then wraps to 0; otherwise it increments.
- Decision on a tick, using `legal_moves` as sampled that cycle. Let `d` be the direction applied this tick:
  - Aligned (`at_center`):
    - If `pend`≠0 and `pend`&`legal_moves`≠0: `d`=`pend`, clear `pend`, state MOVE.
    - Else if state MOVE and `current_direction`&`legal_moves`≠0: `d`=`current_direction`.
    - Else: state STOP; `current_direction` is retained; no step.
  - Not aligned (MOVE only):
    - If `pend` is the exact opposite of `current_direction`: `d`=`pend`, clear `pend` (reversal).
    - Otherwise `d`=`current_direction`.
- Step in `d`, same tick:
  - R: `xpos`+=STEP; `xoff`=(`xoff`+STEP==CELL)?0:`xoff`+STEP.
  - L: `xpos`-=STEP; `xoff`=(`xoff`==0)?CELL-STEP:`xoff`-STEP.
  - D/U: the same arithmetic on `ypos`/`yoff`.
  - `current_direction` ← `d`.
- Bounds guard:
  - x is limited to [X0, X0+7*CELL] (150..570) and y to [Y0, Y0+7*CELL] (34..454).
  - A step that would leave these bounds is suppressed and the state goes to STOP.
- Unsigned 10-bit arithmetic; no wrap-around is ever produced.

## Timing
- Position, direction, state and offsets update on the clock edge at the end of the tick cycle.
- `step_pulse` is registered: high for exactly the cycle after an edge that changed `xpos`/`ypos`.
- `legal_moves` is assumed valid in the same cycle as the current outputs; no extra input pipeline.
- `rst_n` low clears everything asynchronously, including mid-step. Operation resumes with the first tick TICK_DIV cycles after release.
- `respawn` takes precedence over a simultaneous tick and over `btn` input.
- `game_en` low for any length: no state changes; `step_pulse` stays 0.
- Cell traversal at defaults: CELL/STEP = 30 ticks.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, `btn` idle → `xpos`=330, `ypos`=274, `current_direction`=0000, `moving`=0, `at_center`=1; no `step_pulse` after 20 cycles.
- Hold `btn`=0001 with `legal_moves`=0001 → first tick: `ypos`=276, `current_direction`=0001, `step_pulse` one cycle later. After 30 ticks: `ypos`=334, `at_center`=1.
- Moving down, `legal_moves`=0001, press right (`pend`=0100) mid-cell → no turn until centre. At centre with `legal_moves`=0101: turns; `xpos`=332 on that tick.
- Moving down mid-cell (`yoff`=10), press up (0010) → next tick `ypos` decreases by 2, `current_direction`=0010; `legal_moves` ignored.
- At centre, `legal_moves`=0000, moving down → state STOP, `moving`=0, position unchanged, `current_direction` stays 0001.
- Mid-cell, assert `respawn` on the tick cycle → next cycle: 330/274, STOP, `pend`=0. Pull `rst_n` low mid-cell → async return to reset values.
